// File: rtl/tt_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, default widths and the divide-by-zero result pattern.
package tt_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  localparam logic [7:0] QUO_DZ = 8'hFF;
  localparam logic [3:0] REM_DZ = 4'hF;

endpackage

// File: rtl/seq_div_core.sv
// Restoring divider core: one quotient bit per enabled clock, start/busy/done handshake.
// The dividend register shifts into the remainder while quotient bits fill from the right.
module seq_div_core
  import tt_div_pkg::*;
#(
  parameter int            DW     = DEF_DW,
  parameter int            VW     = DEF_VW,
  parameter logic [DW-1:0] DZ_QUO = {DW{1'b1}},
  parameter logic [VW-1:0] DZ_REM = {VW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem
);

  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t    state_r, state_nx;
  logic          busy_r, busy_nx;
  logic          done_r, done_nx;
  logic          dzp_r, dzp_nx;
  logic [DW-1:0] quo_r, quo_nx;
  logic [VW:0]   rem_r, rem_nx;
  logic [VW-1:0] dvs_r, dvs_nx;
  logic [CW-1:0] cnt_r, cnt_nx;

  logic [VW:0]   shift_s;
  logic [VW+1:0] diff_s;
  logic          accept_s;
  logic          unused_rem_msb_s;

  // Trial subtraction; one extra bit beyond the remainder width acts as the sign.
  always_comb begin
    shift_s = {rem_r[VW-1:0], quo_r[DW-1]};
    diff_s  = {1'b0, shift_s} - {2'b00, dvs_r};
  end

  // A pending divide-by-zero blocks a new accept so its done pulse is never skipped.
  assign accept_s = ena && start && (state_r != S_BUSY) && !dzp_r;

  // Next-state and datapath update.
  always_comb begin
    state_nx = state_r;
    busy_nx  = busy_r;
    done_nx  = done_r;
    dzp_nx   = dzp_r;
    quo_nx   = quo_r;
    rem_nx   = rem_r;
    dvs_nx   = dvs_r;
    cnt_nx   = cnt_r;
    if (!ena) begin
      state_nx = state_r;
    end else if (dzp_r) begin
      state_nx = S_DONE;
      done_nx  = 1'b1;
      dzp_nx   = 1'b0;
      quo_nx   = DZ_QUO;
      rem_nx   = {1'b0, DZ_REM};
    end else if (accept_s) begin
      quo_nx  = dividend;
      rem_nx  = '0;
      dvs_nx  = divisor;
      cnt_nx  = CNT_LOAD;
      done_nx = 1'b0;
      if (divisor != '0) begin
        state_nx = S_BUSY;
        busy_nx  = 1'b1;
      end else begin
        dzp_nx  = 1'b1;
        busy_nx = 1'b0;
      end
    end else begin
      case (state_r)
        S_BUSY: begin
          quo_nx = {quo_r[DW-2:0], ~diff_s[VW+1]};
          if (!diff_s[VW+1]) begin
            rem_nx = diff_s[VW:0];
          end else begin
            rem_nx = shift_s;
          end
          cnt_nx = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_BUSY;
          end
        end
        S_IDLE, S_DONE: begin
          state_nx = state_r;
        end
        default: begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dzp_r   <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      dzp_r   <= dzp_nx;
      quo_r   <= quo_nx;
      rem_r   <= rem_nx;
      dvs_r   <= dvs_nx;
      cnt_r   <= cnt_nx;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign quo  = quo_r;
  assign rem  = rem_r[VW-1:0];

  // The remainder MSB is always clear once an iteration settles, so it is not exported.
  assign unused_rem_msb_s = rem_r[VW];

endmodule

// File: rtl/tt_um_seq_divider.sv
// TinyTapeout wrapper for the 8/4 sequential divider: pin mapping and result mux.
// uio[7:6] are driven outputs (done, busy); uio[5:0] are inputs.
module tt_um_seq_divider
  import tt_div_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [DEF_DW-1:0] quo_s;
  logic [DEF_VW-1:0] rem_s;
  logic              busy_s;
  logic              done_s;
  logic              unused_uio_s;

  seq_div_core #(
    .DW    (DEF_DW),
    .VW    (DEF_VW),
    .DZ_QUO(QUO_DZ),
    .DZ_REM(REM_DZ)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (uio_in[4]),
    .dividend(ui_in),
    .divisor (uio_in[3:0]),
    .busy    (busy_s),
    .done    (done_s),
    .quo     (quo_s),
    .rem     (rem_s)
  );

  // rsel picks quotient or zero-extended remainder; never touches core state.
  always_comb begin
    if (uio_in[5]) begin
      uo_out = {4'b0000, rem_s};
    end else begin
      uo_out = quo_s;
    end
  end

  assign uio_out      = {done_s, busy_s, 6'b00_0000};
  assign uio_oe       = 8'b1100_0000;
  assign unused_uio_s = ^uio_in[7:6];

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Scoreboard bench for tt_um_seq_divider: stimulus queues expected results,
// a monitor pops and compares on every rising edge of done.
module tb_tt_um_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       start;
  logic       rsel;
  logic [3:0] dvs;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  assign uio_in = {2'b00, rsel, start, dvs};

  tt_um_seq_divider dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: owns rsel, reads both halves of the result when done rises.
  initial begin : monitor
    logic done_prev;
    logic done_now;
    exp_t e;
    rsel      = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      done_now = uio_out[7];
      if (rst_n && done_now && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done_now}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          rsel = 1'b0;
          #1;
          chk("quotient", {24'd0, uo_out}, {24'd0, e.q});
          rsel = 1'b1;
          #1;
          chk("remainder", {24'd0, uo_out}, {28'd0, e.r});
          rsel = 1'b0;
        end
      end
      done_prev = rst_n ? done_now : 1'b0;
    end
  end

  initial begin : guard
    #1_000_000;
    $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1, "bench did not terminate");
  end

  // Present operands at a negedge, queue the expectation, pulse start for one edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input int unsigned lat);
    exp_t e;
    ui_in = a;
    dvs   = b;
    e.q   = eq;
    e.r   = er;
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (uio_out[6]) nbusy++;
      if (uio_out[7]) break;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, uio_out[7]}, 32'd1);
  endtask

  initial begin : stim
    int nb;
    logic [7:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] vq [3];
    logic [3:0] vr [3];
    va = '{8'd200, 8'd91, 8'd250};
    vb = '{4'd7, 4'd6, 4'd13};
    vq = '{8'd28, 8'd15, 8'd19};
    vr = '{4'd4, 4'd1, 4'd3};

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    ui_in = 8'd0;
    dvs   = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_uo_out", {24'd0, uo_out}, 32'd0);
    chk("reset_uio_out", {24'd0, uio_out}, 32'd0);
    chk("uio_oe", {24'd0, uio_oe}, 32'h0000_00C0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_uio_out", {24'd0, uio_out}, 32'd0);

    // 1. 200/7 with busy width
    issue(8'd200, 4'd7, 8'd28, 4'd4, 9);
    chk("busy_after_accept", {31'd0, uio_out[6]}, 32'd1);
    wait_done(nb);
    chk("busy_cycles", nb, 32'd8);
    chk("busy_at_done", {31'd0, uio_out[6]}, 32'd0);

    // 2. boundary operands
    issue(8'd255, 4'd1, 8'd255, 4'd0, 9);
    wait_done(nb);
    issue(8'd5, 4'd9, 8'd0, 4'd5, 9);
    wait_done(nb);
    issue(8'd0, 4'd15, 8'd0, 4'd0, 9);
    wait_done(nb);

    // 3. divide by zero
    issue(8'd77, 4'd0, 8'hFF, 4'hF, 2);
    wait_done(nb);
    chk("dz_busy_cycles", nb, 32'd0);

    // 4. start held through three ops, operands changed mid-BUSY
    ui_in = va[0];
    dvs   = vb[0];
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back('{q: vq[j], r: vr[j], cyc: cyc + 9});
      @(negedge clk);
      if (j > 0) chk("done_pulse_width", {31'd0, uio_out[7]}, 32'd0);
      if (j < 2) begin
        ui_in = va[j+1];
        dvs   = vb[j+1];
      end else begin
        start = 1'b0;
        ui_in = 8'hA5;
        dvs   = 4'd2;
      end
      repeat (8) @(negedge clk);
      chk("held_done", {31'd0, uio_out[7]}, 32'd1);
    end

    // 5. reset mid-operation aborts; next op is clean
    issue(8'd200, 4'd7, 8'd0, 4'd0, 0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'd0, uio_out[6]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_uio_out", {24'd0, uio_out}, 32'd0);
    chk("abort_uo_out", {24'd0, uo_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd100, 4'd3, 8'd33, 4'd1, 9);
    wait_done(nb);

    // 6. ena low for 5 cycles during BUSY
    issue(8'd143, 4'd11, 8'd13, 4'd0, 14);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_while_frozen", {31'd0, uio_out[6]}, 32'd1);
    ena = 1'b1;
    wait_done(nb);

    // Full operand sweep against arithmetic reference
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) issue(8'(a), 4'(b), 8'hFF, 4'hF, 2);
        else        issue(8'(a), 4'(b), 8'(a / b), 4'(a % b), 9);
        wait_done(nb);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
